keypad_bcd_encoder: RTL and testbench

- Sequential inverse of the team's one-hot BCD digit decoder: takes nine discrete key lines (digits 1..9) and produces a registered 4-bit BCD code.
- Synchronises, debounces, rejects multi-key presses, emits one code per press.
- Hands each code to downstream logic (display/accumulator) over a VALID/READY handshake.

---
 rtl/keypad_bcd_encoder.sv | 167 ++++++++++++++++
 tb/tb_keypad_bcd_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/keypad_bcd_encoder.sv
// Nine-key keypad to BCD encoder: synchronises and debounces the key lines, rejects
// multi-key presses, and hands one code per press downstream over VALID/READY.
module keypad_bcd_encoder #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic K1,
  input  logic K2,
  input  logic K3,
  input  logic K4,
  input  logic K5,
  input  logic K6,
  input  logic K7,
  input  logic K8,
  input  logic K9,
  input  logic READY,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic A3,
  output logic VALID,
  output logic ERR,
  output logic OVF
);

  localparam logic [7:0] DB = 8'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  state_t     state;
  logic [8:0] key_raw;
  logic [8:0] sync_q1;
  logic [8:0] sync_q2;
  logic [8:0] pat;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [3:0] code;
  logic       valid_q;
  logic       err_q;
  logic       ovf_q;

  logic       accept;
  logic [8:0] acc_pat;
  logic       one_hot;
  logic [3:0] digit;

  assign key_raw = {K9, K8, K7, K6, K5, K4, K3, K2, K1};
  assign cnt_inc = cnt + 8'd1;

  // With DEBOUNCE=1 the first nonzero pattern seen in IDLE is accepted directly.
  always_comb begin
    accept  = 1'b0;
    acc_pat = pat;
    case (state)
      IDLE: begin
        if (sync_q2 != '0 && DB == 8'd1) begin
          accept  = 1'b1;
          acc_pat = sync_q2;
        end
      end
      QUAL: begin
        if (sync_q2 == pat && cnt_inc >= DB) begin
          accept = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    one_hot = (acc_pat != '0) && ((acc_pat & (acc_pat - 9'd1)) == '0);
    digit   = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (acc_pat[i]) digit = 4'(i + 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      state   <= IDLE;
      pat     <= '0;
      cnt     <= '0;
      code    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
      err_q   <= 1'b0;

      // A same-edge accept overrides the handshake clear below.
      if (valid_q && READY) valid_q <= 1'b0;

      if (accept) begin
        if (one_hot) begin
          if (!valid_q || READY) begin
            code    <= digit;
            valid_q <= 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (sync_q2 != '0) begin
            pat <= sync_q2;
            if (DB == 8'd1) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              state <= QUAL;
              cnt   <= 8'd1;
            end
          end else begin
            cnt <= '0;
          end
        end
        QUAL: begin
          if (sync_q2 == pat) begin
            if (cnt_inc >= DB) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else if (sync_q2 == '0) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            pat <= sync_q2;
            cnt <= 8'd1;
          end
        end
        HOLD: begin
          if (sync_q2 == '0) begin
            if (cnt_inc >= DB) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A0    = code[0];
  assign A1    = code[1];
  assign A2    = code[2];
  assign A3    = code[3];
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Directed bench for keypad_bcd_encoder at DEBOUNCE=4; edges counted from the
// first edge after a key pattern is applied.
module tb_keypad_bcd_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] k = '0;
  logic       ready = 1'b1;
  logic       a0, a1, a2, a3, valid, err, ovf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  keypad_bcd_encoder #(.DEBOUNCE(4)) dut (
    .CLK(clk), .RST(rst),
    .K1(k[0]), .K2(k[1]), .K3(k[2]), .K4(k[3]), .K5(k[4]),
    .K6(k[5]), .K7(k[6]), .K8(k[7]), .K9(k[8]),
    .READY(ready),
    .A0(a0), .A1(a1), .A2(a2), .A3(a3),
    .VALID(valid), .ERR(err), .OVF(ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  function automatic logic [3:0] code();
    return {a3, a2, a1, a0};
  endfunction

  logic seen;

  initial begin
    // Reset
    ticks(2);
    check("rst_code", 32'(code()), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(ovf), 0);

    // 1: clean K5 press, READY=1
    rst = 1'b0; ready = 1'b1; k = 9'b0_0001_0000;
    seen = 1'b0;
    for (int i = 1; i <= 5; i++) begin tick(); if (valid) seen = 1'b1; end
    check("t1_early", 32'(seen), 0);
    tick();
    check("t1_valid", 32'(valid), 1);
    check("t1_code", 32'(code()), 5);
    tick();
    check("t1_clear", 32'(valid), 0);
    seen = 1'b0;
    for (int i = 0; i < 13; i++) begin tick(); if (valid || err) seen = 1'b1; end
    check("t1_norepeat", 32'(seen), 0);
    check("t1_ovf", 32'(ovf), 0);
    k = '0; ticks(10);

    // 2: K3 bounce 1,0,1,1,0 then stable; S stable after edge 7, accept at edge 11
    seen = 1'b0;
    k = 9'b0_0000_0100; tick(); if (valid) seen = 1'b1;
    k = '0;             tick(); if (valid) seen = 1'b1;
    k = 9'b0_0000_0100; tick(); if (valid) seen = 1'b1;
    tick(); if (valid) seen = 1'b1;
    k = '0;             tick(); if (valid) seen = 1'b1;
    k = 9'b0_0000_0100;
    for (int i = 6; i <= 10; i++) begin tick(); if (valid) seen = 1'b1; end
    check("t2_bounce", 32'(seen), 0);
    tick();
    check("t2_valid", 32'(valid), 1);
    check("t2_code", 32'(code()), 3);
    tick();
    check("t2_clear", 32'(valid), 0);
    k = '0; ticks(10);

    // 3: K3+K7 together -> one-cycle ERR, then K9
    k = 9'b0_0100_0100;
    ticks(5);
    check("t3_err_pre", 32'(err), 0);
    tick();
    check("t3_err", 32'(err), 1);
    check("t3_novalid", 32'(valid), 0);
    tick();
    check("t3_err_pulse", 32'(err), 0);
    check("t3_code_kept", 32'(code()), 3);
    k = '0; ticks(10);
    k = 9'b1_0000_0000;
    ticks(6);
    check("t3_k9_valid", 32'(valid), 1);
    check("t3_k9_code", 32'(code()), 9);
    k = '0; ticks(10);

    // 4: READY=0 holds K2, K8 accept overflows
    ready = 1'b0;
    k = 9'b0_0000_0010;
    ticks(6);
    check("t4_k2_valid", 32'(valid), 1);
    check("t4_k2_code", 32'(code()), 2);
    k = '0; ticks(10);
    check("t4_held", 32'(valid), 1);
    k = 9'b0_1000_0000;
    ticks(5);
    check("t4_ovf_pre", 32'(ovf), 0);
    tick();
    check("t4_ovf", 32'(ovf), 1);
    check("t4_code_kept", 32'(code()), 2);
    check("t4_valid_kept", 32'(valid), 1);
    ready = 1'b1;
    tick();
    check("t4_drain", 32'(valid), 0);
    k = '0; ticks(10);
    check("t4_ovf_sticky", 32'(ovf), 1);

    // 5: back-to-back K1 then K4 with READY=1, then same-edge reload with K7
    k = 9'b0_0000_0001;
    ticks(6);
    check("t5_k1_valid", 32'(valid), 1);
    check("t5_k1_code", 32'(code()), 1);
    tick();
    check("t5_k1_clear", 32'(valid), 0);
    k = '0; ticks(10);
    k = 9'b0_0000_1000;
    ticks(6);
    check("t5_k4_valid", 32'(valid), 1);
    check("t5_k4_code", 32'(code()), 4);
    ready = 1'b0;
    k = '0; ticks(10);
    check("t5_k4_held", 32'(valid), 1);
    k = 9'b0_0100_0000;
    ticks(5);
    ready = 1'b1;
    tick();
    check("t5_reload_valid", 32'(valid), 1);
    check("t5_reload_code", 32'(code()), 7);
    tick();
    check("t5_reload_clear", 32'(valid), 0);
    check("t5_code_hold", 32'(code()), 7);
    k = '0; ticks(10);

    // 6: K6 held, RST at edge 4 while in QUAL
    k = 9'b0_0010_0000;
    ticks(3);
    rst = 1'b1;
    tick();
    check("t6_rst_code", 32'(code()), 0);
    check("t6_rst_valid", 32'(valid), 0);
    check("t6_rst_ovf", 32'(ovf), 0);
    check("t6_rst_err", 32'(err), 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (valid) seen = 1'b1; end
    check("t6_early", 32'(seen), 0);
    tick();
    check("t6_valid", 32'(valid), 1);
    check("t6_code", 32'(code()), 6);
    k = '0; ticks(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
